multicycle_controller: RTL and testbench
========================================

Name: multicycle_controller

Overview:
- Main control FSM for the multi-cycle RV32I datapath; generational successor to the single-cycle opcode decoder.
- Sequences each instruction through Fetch/Decode/Execute/Memory/Writeback over several cycles, sharing one ALU and one unified memory port.
- Adds a memory ready handshake, JALR/LUI/AUIPC support, illegal-opcode trapping and a retire pulse.
- Sits between the instruction register (op/funct fields) and the datapath muxes; the ALU decoder consumes ALUOp.

Parameters:
- MEM_WAIT_EN, 1, 1 = honour mem_ready in memory states; 0 = treat memory as single-cycle (mem_ready ignored, taken as 1).
- ENABLE_JALR, 1, 1 = decode opcode 1100111; 0 = treat it as illegal.
- ENABLE_UTYPE, 1, 1 = decode LUI 0110111 / AUIPC 0010111; 0 = treat both as illegal.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- op  in  7  opcode from instruction register; stable from the cycle after IRWrite.
- mem_ready  in  1  memory access completes this cycle.
- PCUpdate  out  1  PC register write enable (Branch logic external).
- Branch  out  1  conditional PC write request (gated externally with Zero/compare).
- IRWrite  out  1  instruction register and OldPC write enable.
- RegWrite  out  1  register file write enable.
- MemWrite  out  1  data memory write strobe.
- AdrSrc  out  1  0 = PC, 1 = Result as memory address.
- ResultSrc  out  2  00 ALUOut, 01 Data, 10 ALUResult.
- ALUSrcA  out  2  00 PC, 01 OldPC, 10 regA, 11 zero.
- ALUSrcB  out  2  00 regB, 01 ImmExt, 10 constant 4.
- ALUOp  out  2  00 add, 01 subtract/compare, 10 from funct fields.
- ImmSrc  out  3  000 I, 001 S, 010 B, 011 J, 100 U; combinational from op; 000 for unknown op.
- illegal_op  out  1  sticky flag set on entry to TRAP.
- instr_retire  out  1  one-cycle pulse on the last cycle of each completed instruction.

Behaviour:
- Outputs are Moore per state except IRWrite/PCUpdate in FETCH, which are gated by mem_ready. Unlisted outputs are 0 and ResultSrc = 00.
- Reset: state <= FETCH and illegal_op <= 0 on any edge with reset=1, including mid-instruction. While in reset, all enables (PCUpdate, Branch, IRWrite, RegWrite, MemWrite) are 0.
- FETCH: AdrSrc=0, A=00, B=10, ALUOp=00, ResultSrc=10; IRWrite=PCUpdate=rdy. Moves to DECODE when rdy, otherwise holds. (rdy = mem_ready | ~MEM_WAIT_EN.)
- DECODE: A=01, B=01, ALUOp=00, which computes the branch/JAL target into ALUOut. Dispatch on op:
  - 0000011 and 0100011 -> MEMADR
  - 0110011 -> EXECR
  - 0010011 -> EXECI
  - 1100011 -> BEQ
  - 1101111 -> JAL
  - 1100111 -> JALR
  - 0110111 -> LUI
  - 0010111 -> AUIPC
  - anything else -> TRAP
- MEMADR: A=10, B=01, ALUOp=00 -> MEMREAD if op=0000011, else MEMWRITE.
- MEMREAD: AdrSrc=1, ResultSrc=00; holds until rdy, then -> MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1, retire -> FETCH.
- MEMWRITE: AdrSrc=1, MemWrite=1 held each cycle until rdy; on rdy, retire -> FETCH.
- EXECR: A=10, B=00, ALUOp=10 -> ALUWB.
- EXECI: A=10, B=01, ALUOp=10 -> ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1, retire -> FETCH.
- JAL: A=01, B=10, ALUOp=00, ResultSrc=00, PCUpdate=1 -> ALUWB.
- JALR: A=10, B=01, ALUOp=00 -> JAL. The target lands in ALUOut; the datapath clears bit 0.
- LUI: A=11, B=01, ALUOp=00 -> ALUWB.
- AUIPC: A=01, B=01, ALUOp=00 -> ALUWB.
- BEQ: A=10, B=00, ALUOp=01, ResultSrc=00, Branch=1, retire -> FETCH.
- TRAP: terminal; all enables 0; illegal_op=1; no retire. Exits only via reset.
- instr_retire is asserted exactly in the cycle whose next state is FETCH (excluding reset).
- State register is 4 bits; unreachable encodings -> FETCH with outputs 0.
- Cycle counts with rdy always 1: lw 5, sw 4, R/I-type 4, beq 3, jal 4, jalr 5, lui/auipc 4.

Test Plan:
- MEM_WAIT_EN=0, mem_ready=0: program add (0110011), lw, sw, beq. Expect retire pulses 4, 5, 4, 3 cycles after each FETCH entry. RegWrite only in ALUWB/MEMWB; MemWrite exactly 1 cycle for sw.
- MEM_WAIT_EN=1, lw with mem_ready low for 3 cycles in FETCH and 2 in MEMREAD:
  - IRWrite/PCUpdate pulse once, on the ready cycle.
  - lw retires after 10 cycles total.
  - sw with 2 wait cycles: MemWrite high 3 consecutive cycles.
- jal then jalr: jal shows PCUpdate=1 with A=01, B=10 in JAL, then RegWrite in ALUWB. jalr visits JALR (A=10, B=01) then JAL; 5 cycles to retire.
- op=0110111 with ENABLE_UTYPE=1 -> A=11, B=01, ImmSrc=100, retire at cycle 4. Same op with ENABLE_UTYPE=0 -> TRAP, illegal_op=1 and stays 1 for 20 cycles, no enables asserted.
- Assert reset for 1 cycle while in MEMWRITE with MemWrite=1: next cycle state=FETCH, MemWrite=0, illegal_op cleared. The next instruction executes normally.
- Sweep all 128 op values through DECODE: ImmSrc matches the table (000 for unknown), and exactly the listed 9 opcodes avoid TRAP when both enables are 1.

Source files
------------

// File: rtl/multicycle_controller.sv
// Main control FSM for the multi-cycle RV32I datapath.
// Sequences each instruction through fetch/decode/execute/memory/writeback and drives the datapath mux selects.
module multicycle_controller #(
    parameter bit MEM_WAIT_EN  = 1'b1,
    parameter bit ENABLE_JALR  = 1'b1,
    parameter bit ENABLE_UTYPE = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic       mem_ready,
    output logic       PCUpdate,
    output logic       Branch,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic       AdrSrc,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [2:0] ImmSrc,
    output logic       illegal_op,
    output logic       instr_retire
);

    // state    | meaning
    // FETCH    | read instruction at PC, PC+4 -> PC on ready
    // DECODE   | OldPC+imm -> ALUOut (branch/jal target), dispatch on op
    // MEMADR   | rs1+imm address calculation for lw/sw
    // MEMREAD  | data read at ALUOut, wait for ready
    // MEMWB    | load data -> rd
    // MEMWRITE | store strobe held until ready
    // EXECR    | rs1 op rs2
    // EXECI    | rs1 op imm
    // ALUWB    | ALUOut -> rd
    // BEQ      | compare rs1/rs2, conditional PC write of DECODE target
    // JAL      | PC <- ALUOut target, OldPC+4 -> ALUOut for link
    // JALR     | rs1+imm -> ALUOut, then reuse JAL
    // LUI      | 0+imm -> ALUOut
    // AUIPC    | OldPC+imm -> ALUOut
    // TRAP     | illegal opcode, parked until reset
    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECR    = 4'd6,
        EXECI    = 4'd7,
        ALUWB    = 4'd8,
        BEQ      = 4'd9,
        JAL      = 4'd10,
        JALR     = 4'd11,
        LUI      = 4'd12,
        AUIPC    = 4'd13,
        TRAP     = 4'd14
    } state_t;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    state_t state;
    state_t next_state;
    logic   rdy;
    logic   pc_s, br_s, ir_s, rw_s, mw_s, ret_s;

    assign rdy = mem_ready | ~MEM_WAIT_EN;

    always_comb begin
        next_state = FETCH;
        case (state)
            FETCH:    next_state = rdy ? DECODE : FETCH;
            DECODE: begin
                case (op)
                    OP_LOAD, OP_STORE: next_state = MEMADR;
                    OP_R:              next_state = EXECR;
                    OP_I:              next_state = EXECI;
                    OP_BEQ:            next_state = BEQ;
                    OP_JAL:            next_state = JAL;
                    OP_JALR:           next_state = ENABLE_JALR ? JALR : TRAP;
                    OP_LUI:            next_state = ENABLE_UTYPE ? LUI : TRAP;
                    OP_AUIPC:          next_state = ENABLE_UTYPE ? AUIPC : TRAP;
                    default:           next_state = TRAP;
                endcase
            end
            MEMADR:   next_state = (op == OP_LOAD) ? MEMREAD : MEMWRITE;
            MEMREAD:  next_state = rdy ? MEMWB : MEMREAD;
            MEMWB:    next_state = FETCH;
            MEMWRITE: next_state = rdy ? FETCH : MEMWRITE;
            EXECR:    next_state = ALUWB;
            EXECI:    next_state = ALUWB;
            ALUWB:    next_state = FETCH;
            BEQ:      next_state = FETCH;
            JAL:      next_state = ALUWB;
            JALR:     next_state = JAL;
            LUI:      next_state = ALUWB;
            AUIPC:    next_state = ALUWB;
            TRAP:     next_state = TRAP;
            default:  next_state = FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= FETCH;
            illegal_op <= 1'b0;
        end else begin
            state <= next_state;
            if (next_state == TRAP)
                illegal_op <= 1'b1;
        end
    end

    // Moore decode; only the FETCH write enables and the store retire look at ready.
    always_comb begin
        pc_s      = 1'b0;
        br_s      = 1'b0;
        ir_s      = 1'b0;
        rw_s      = 1'b0;
        mw_s      = 1'b0;
        ret_s     = 1'b0;
        AdrSrc    = 1'b0;
        ResultSrc = 2'b00;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        ALUOp     = 2'b00;
        case (state)
            FETCH: begin
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                ir_s      = rdy;
                pc_s      = rdy;
            end
            DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
            end
            MEMADR, JALR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
            end
            MEMREAD:  AdrSrc = 1'b1;
            MEMWB: begin
                ResultSrc = 2'b01;
                rw_s      = 1'b1;
                ret_s     = 1'b1;
            end
            MEMWRITE: begin
                AdrSrc = 1'b1;
                mw_s   = 1'b1;
                ret_s  = rdy;
            end
            EXECR: begin
                ALUSrcA = 2'b10;
                ALUOp   = 2'b10;
            end
            EXECI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                ALUOp   = 2'b10;
            end
            ALUWB: begin
                rw_s  = 1'b1;
                ret_s = 1'b1;
            end
            JAL: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b10;
                pc_s    = 1'b1;
            end
            LUI: begin
                ALUSrcA = 2'b11;
                ALUSrcB = 2'b01;
            end
            AUIPC: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
            end
            BEQ: begin
                ALUSrcA = 2'b10;
                ALUOp   = 2'b01;
                br_s    = 1'b1;
                ret_s   = 1'b1;
            end
            default: ;
        endcase
    end

    assign PCUpdate     = pc_s  & ~reset;
    assign Branch       = br_s  & ~reset;
    assign IRWrite      = ir_s  & ~reset;
    assign RegWrite     = rw_s  & ~reset;
    assign MemWrite     = mw_s  & ~reset;
    assign instr_retire = ret_s & ~reset;

    always_comb begin
        case (op)
            OP_LOAD, OP_I, OP_JALR: ImmSrc = 3'b000;
            OP_STORE:               ImmSrc = 3'b001;
            OP_BEQ:                 ImmSrc = 3'b010;
            OP_JAL:                 ImmSrc = 3'b011;
            OP_LUI, OP_AUIPC:       ImmSrc = 3'b100;
            default:                ImmSrc = 3'b000;
        endcase
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: directed vector table against a default instance and a
// single-cycle-memory / reduced-ISA instance, plus an opcode sweep through DECODE.
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic       mem_ready;
    logic [6:0] op;

    logic       m_pc, m_br, m_ir, m_rw, m_mw, m_adr, m_ill, m_ret;
    logic [1:0] m_res, m_a, m_b, m_aop;
    logic [2:0] m_imm;
    logic       a_pc, a_br, a_ir, a_rw, a_mw, a_adr, a_ill, a_ret;
    logic [1:0] a_res, a_a, a_b, a_aop;
    logic [2:0] a_imm;

    multicycle_controller dut_main (
        .clk(clk), .reset(reset), .op(op), .mem_ready(mem_ready),
        .PCUpdate(m_pc), .Branch(m_br), .IRWrite(m_ir), .RegWrite(m_rw), .MemWrite(m_mw),
        .AdrSrc(m_adr), .ResultSrc(m_res), .ALUSrcA(m_a), .ALUSrcB(m_b), .ALUOp(m_aop),
        .ImmSrc(m_imm), .illegal_op(m_ill), .instr_retire(m_ret)
    );

    multicycle_controller #(.MEM_WAIT_EN(1'b0), .ENABLE_JALR(1'b0), .ENABLE_UTYPE(1'b0)) dut_alt (
        .clk(clk), .reset(reset), .op(op), .mem_ready(mem_ready),
        .PCUpdate(a_pc), .Branch(a_br), .IRWrite(a_ir), .RegWrite(a_rw), .MemWrite(a_mw),
        .AdrSrc(a_adr), .ResultSrc(a_res), .ALUSrcA(a_a), .ALUSrcB(a_b), .ALUOp(a_aop),
        .ImmSrc(a_imm), .illegal_op(a_ill), .instr_retire(a_ret)
    );

    always #5 clk = ~clk;

    // {PCUpdate,Branch,IRWrite,RegWrite,MemWrite,AdrSrc}_ResultSrc_A_B_ALUOp_ImmSrc_{illegal,retire}
    logic [18:0] out_m, out_a;
    assign out_m = {m_pc, m_br, m_ir, m_rw, m_mw, m_adr, m_res, m_a, m_b, m_aop, m_imm, m_ill, m_ret};
    assign out_a = {a_pc, a_br, a_ir, a_rw, a_mw, a_adr, a_res, a_a, a_b, a_aop, a_imm, a_ill, a_ret};

    localparam logic [18:0] E_FETCH_RDY  = 19'b101000_10_00_10_00_000_00;
    localparam logic [18:0] E_FETCH_WAIT = 19'b000000_10_00_10_00_000_00;
    localparam logic [18:0] E_DECODE     = 19'b000000_00_01_01_00_000_00;
    localparam logic [18:0] E_MEMADR     = 19'b000000_00_10_01_00_000_00;
    localparam logic [18:0] E_MEMREAD    = 19'b000001_00_00_00_00_000_00;
    localparam logic [18:0] E_MEMWB      = 19'b000100_01_00_00_00_000_00;
    localparam logic [18:0] E_MEMWRITE   = 19'b000011_00_00_00_00_000_00;
    localparam logic [18:0] E_MW_RST     = 19'b000001_00_00_00_00_000_00;
    localparam logic [18:0] E_EXECR      = 19'b000000_00_10_00_10_000_00;
    localparam logic [18:0] E_EXECI      = 19'b000000_00_10_01_10_000_00;
    localparam logic [18:0] E_ALUWB      = 19'b000100_00_00_00_00_000_00;
    localparam logic [18:0] E_JAL        = 19'b100000_00_01_10_00_000_00;
    localparam logic [18:0] E_JALR       = 19'b000000_00_10_01_00_000_00;
    localparam logic [18:0] E_LUI        = 19'b000000_00_11_01_00_000_00;
    localparam logic [18:0] E_AUIPC      = 19'b000000_00_01_01_00_000_00;
    localparam logic [18:0] E_BEQ        = 19'b010000_00_10_00_01_000_00;
    localparam logic [18:0] E_TRAP       = 19'b000000_00_00_00_00_000_00;
    localparam logic [18:0] RET   = 19'b1;
    localparam logic [18:0] ILL   = 19'b10;
    localparam logic [18:0] IMM_S = 19'b001_00;
    localparam logic [18:0] IMM_B = 19'b010_00;
    localparam logic [18:0] IMM_J = 19'b011_00;
    localparam logic [18:0] IMM_U = 19'b100_00;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    typedef struct {
        logic        sel;   // 0 = dut_main, 1 = dut_alt
        logic        rst;
        logic [6:0]  op;
        logic        rdy;
        logic        chk;
        logic [18:0] exp;
    } vec_t;

    vec_t vq[$];
    int   errors = 0;
    int   checks = 0;
    int   legal_cnt = 0;

    task automatic add(input logic sel, input logic rst, input logic [6:0] o, input logic r,
                       input logic chk, input logic [18:0] e);
        vec_t v;
        v.sel = sel; v.rst = rst; v.op = o; v.rdy = r; v.chk = chk; v.exp = e;
        vq.push_back(v);
    endtask

    task automatic step(input logic rst, input logic [6:0] o, input logic r);
        @(negedge clk);
        reset = rst;
        op = o;
        mem_ready = r;
        #2;
    endtask

    task automatic check(input string name, input logic [18:0] act, input logic [18:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %05h expected %05h", name, act, exp);
        end
    endtask

    function automatic logic [2:0] imm_of(input logic [6:0] o);
        case (o)
            OP_STORE:          return 3'b001;
            OP_BEQ:            return 3'b010;
            OP_JAL:            return 3'b011;
            OP_LUI, OP_AUIPC:  return 3'b100;
            default:           return 3'b000;
        endcase
    endfunction

    function automatic logic is_legal(input logic [6:0] o);
        case (o)
            OP_LOAD, OP_STORE, OP_R, OP_I, OP_BEQ, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    initial begin
        reset = 1'b1;
        op = OP_R;
        mem_ready = 1'b0;

        // single-cycle memory: add, lw, sw, beq with mem_ready tied low
        add(1, 0, OP_R, 0, 1, E_FETCH_RDY);
        add(1, 0, OP_R, 0, 1, E_DECODE);
        add(1, 0, OP_R, 0, 1, E_EXECR);
        add(1, 0, OP_R, 0, 1, E_ALUWB | RET);
        add(1, 0, OP_LOAD, 0, 1, E_FETCH_RDY);
        add(1, 0, OP_LOAD, 0, 1, E_DECODE);
        add(1, 0, OP_LOAD, 0, 1, E_MEMADR);
        add(1, 0, OP_LOAD, 0, 1, E_MEMREAD);
        add(1, 0, OP_LOAD, 0, 1, E_MEMWB | RET);
        add(1, 0, OP_STORE, 0, 1, E_FETCH_RDY | IMM_S);
        add(1, 0, OP_STORE, 0, 1, E_DECODE | IMM_S);
        add(1, 0, OP_STORE, 0, 1, E_MEMADR | IMM_S);
        add(1, 0, OP_STORE, 0, 1, E_MEMWRITE | IMM_S | RET);
        add(1, 0, OP_BEQ, 0, 1, E_FETCH_RDY | IMM_B);
        add(1, 0, OP_BEQ, 0, 1, E_DECODE | IMM_B);
        add(1, 0, OP_BEQ, 0, 1, E_BEQ | IMM_B | RET);

        // waited lw: 3 stall cycles in FETCH, 2 in MEMREAD, retire on cycle 10
        for (int i = 0; i < 3; i++) add(0, 0, OP_LOAD, 0, 1, E_FETCH_WAIT);
        add(0, 0, OP_LOAD, 1, 1, E_FETCH_RDY);
        add(0, 0, OP_LOAD, 0, 1, E_DECODE);
        add(0, 0, OP_LOAD, 0, 1, E_MEMADR);
        add(0, 0, OP_LOAD, 0, 1, E_MEMREAD);
        add(0, 0, OP_LOAD, 0, 1, E_MEMREAD);
        add(0, 0, OP_LOAD, 1, 1, E_MEMREAD);
        add(0, 0, OP_LOAD, 0, 1, E_MEMWB | RET);

        // sw with 2 wait cycles: MemWrite held 3 cycles
        add(0, 0, OP_STORE, 1, 1, E_FETCH_RDY | IMM_S);
        add(0, 0, OP_STORE, 0, 1, E_DECODE | IMM_S);
        add(0, 0, OP_STORE, 0, 1, E_MEMADR | IMM_S);
        add(0, 0, OP_STORE, 0, 1, E_MEMWRITE | IMM_S);
        add(0, 0, OP_STORE, 0, 1, E_MEMWRITE | IMM_S);
        add(0, 0, OP_STORE, 1, 1, E_MEMWRITE | IMM_S | RET);

        add(0, 0, OP_JAL, 1, 1, E_FETCH_RDY | IMM_J);
        add(0, 0, OP_JAL, 1, 1, E_DECODE | IMM_J);
        add(0, 0, OP_JAL, 1, 1, E_JAL | IMM_J);
        add(0, 0, OP_JAL, 1, 1, E_ALUWB | IMM_J | RET);
        add(0, 0, OP_JALR, 1, 1, E_FETCH_RDY);
        add(0, 0, OP_JALR, 1, 1, E_DECODE);
        add(0, 0, OP_JALR, 1, 1, E_JALR);
        add(0, 0, OP_JALR, 1, 1, E_JAL);
        add(0, 0, OP_JALR, 1, 1, E_ALUWB | RET);
        add(0, 0, OP_LUI, 1, 1, E_FETCH_RDY | IMM_U);
        add(0, 0, OP_LUI, 1, 1, E_DECODE | IMM_U);
        add(0, 0, OP_LUI, 1, 1, E_LUI | IMM_U);
        add(0, 0, OP_LUI, 1, 1, E_ALUWB | IMM_U | RET);
        add(0, 0, OP_AUIPC, 1, 1, E_FETCH_RDY | IMM_U);
        add(0, 0, OP_AUIPC, 1, 1, E_DECODE | IMM_U);
        add(0, 0, OP_AUIPC, 1, 1, E_AUIPC | IMM_U);
        add(0, 0, OP_AUIPC, 1, 1, E_ALUWB | IMM_U | RET);
        add(0, 0, OP_I, 1, 1, E_FETCH_RDY);
        add(0, 0, OP_I, 1, 1, E_DECODE);
        add(0, 0, OP_I, 1, 1, E_EXECI);
        add(0, 0, OP_I, 1, 1, E_ALUWB | RET);

        // reset while MemWrite is asserted, then a normal add
        add(0, 0, OP_STORE, 1, 1, E_FETCH_RDY | IMM_S);
        add(0, 0, OP_STORE, 0, 1, E_DECODE | IMM_S);
        add(0, 0, OP_STORE, 0, 1, E_MEMADR | IMM_S);
        add(0, 0, OP_STORE, 0, 1, E_MEMWRITE | IMM_S);
        add(0, 1, OP_STORE, 0, 1, E_MW_RST | IMM_S);
        add(0, 0, OP_R, 1, 1, E_FETCH_RDY);
        add(0, 0, OP_R, 0, 1, E_DECODE);
        add(0, 0, OP_R, 0, 1, E_EXECR);
        add(0, 0, OP_R, 0, 1, E_ALUWB | RET);

        // reduced ISA: lui traps and sticks, reset clears, jalr traps too
        add(1, 1, OP_LUI, 0, 0, E_TRAP);
        add(1, 1, OP_LUI, 0, 1, E_FETCH_WAIT | IMM_U);
        add(1, 0, OP_LUI, 0, 1, E_FETCH_RDY | IMM_U);
        add(1, 0, OP_LUI, 0, 1, E_DECODE | IMM_U);
        for (int i = 0; i < 21; i++) add(1, 0, OP_LUI, i[0], 1, E_TRAP | ILL | IMM_U);
        add(1, 1, OP_LUI, 0, 1, E_TRAP | ILL | IMM_U);
        add(1, 0, OP_R, 0, 1, E_FETCH_RDY);
        add(1, 0, OP_R, 0, 1, E_DECODE);
        add(1, 0, OP_R, 0, 1, E_EXECR);
        add(1, 0, OP_R, 0, 1, E_ALUWB | RET);
        add(1, 0, OP_JALR, 0, 1, E_FETCH_RDY);
        add(1, 0, OP_JALR, 0, 1, E_DECODE);
        add(1, 0, OP_JALR, 0, 1, E_TRAP | ILL);

        step(1, OP_R, 0);
        step(1, OP_R, 0);
        check("reset_main", out_m, E_FETCH_WAIT);
        check("reset_alt", out_a, E_FETCH_WAIT);

        foreach (vq[i]) begin
            step(vq[i].rst, vq[i].op, vq[i].rdy);
            if (vq[i].chk)
                check($sformatf("vec%0d", i), vq[i].sel ? out_a : out_m, vq[i].exp);
        end

        // every opcode through DECODE on the full-ISA instance
        for (int v = 0; v < 128; v++) begin
            logic [6:0] o;
            o = v[6:0];
            step(1, o, 1);
            step(0, o, 1);
            step(0, o, 1);
            check($sformatf("imm_op%02h", o), {16'd0, m_imm}, {16'd0, imm_of(o)});
            step(0, o, 1);
            check($sformatf("trap_op%02h", o), {18'd0, m_ill}, {18'd0, ~is_legal(o)});
            if (!m_ill) legal_cnt++;
        end
        check("legal_count", 19'(legal_cnt), 19'd9);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
